// File: rtl/seq_det_pkg.sv
// Shared types and default parameters for the serial bit-pattern detector.
package seq_det_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } det_state_e;

    localparam int unsigned PATTERN_W_DEF = 4;
    localparam logic [15:0] PATTERN_DEF   = 16'b1011;
    localparam int unsigned CNT_W_DEF     = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear and a registered saturation flag.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_sat;
    logic             w_sat_next;

    always_comb begin
        w_count_next = r_count;
        w_sat_next   = r_sat;
        if (clr) begin
            w_count_next = '0;
            w_sat_next   = 1'b0;
        end else if (inc && !r_sat) begin
            w_count_next = r_count + 1'b1;
            w_sat_next   = (w_count_next == CntMax);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_sat   <= w_sat_next;
        end
    end

    assign count = r_count;
    assign sat   = r_sat;

endmodule

// File: rtl/seq_bit_pattern_det.sv
// Serial PATTERN_W-bit pattern detector with saturating match count.
// SEQ_BIT_PATTERN_DET_NONOVERLAP_EN selects non-overlapping detection.
module seq_bit_pattern_det
    import seq_det_pkg::*;
#(
    parameter int unsigned          PATTERN_W = PATTERN_W_DEF,
    parameter logic [PATTERN_W-1:0] PATTERN   = PATTERN_W'(PATTERN_DEF),
    parameter int unsigned          CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             din,
    input  logic             din_val,
    input  logic             clear,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int unsigned      FillW   = $clog2(PATTERN_W + 1);
    localparam logic [FillW-1:0] FillMax = FillW'(PATTERN_W);

    det_state_e             r_state;
    det_state_e             w_state_next;
    logic [PATTERN_W-1:0]   r_hist;
    logic [PATTERN_W-1:0]   w_hist_next;
    logic [PATTERN_W-1:0]   w_hist_shift;
    logic [FillW-1:0]       r_fill;
    logic [FillW-1:0]       w_fill_next;
    logic [FillW-1:0]       w_fill_inc;
    logic                   r_match;
    logic                   w_hit;

    assign w_hist_shift = {r_hist[PATTERN_W-2:0], din};
    assign w_fill_inc   = (r_state == ARMED) ? r_fill : r_fill + 1'b1;
    // A hit needs a full window of real samples, so reset/clear zeros never match.
    assign w_hit = din_val && !clear && (w_fill_inc == FillMax) && (w_hist_shift == PATTERN);

    always_comb begin
        w_state_next = r_state;
        w_hist_next  = r_hist;
        w_fill_next  = r_fill;
        if (clear) begin
            w_state_next = FILL;
            w_hist_next  = '0;
            w_fill_next  = '0;
        end else if (din_val) begin
            w_hist_next  = w_hist_shift;
            w_fill_next  = w_fill_inc;
            w_state_next = (w_fill_inc == FillMax) ? ARMED : FILL;
`ifdef SEQ_BIT_PATTERN_DET_NONOVERLAP_EN
            if (w_hit) begin
                w_fill_next  = '0;
                w_state_next = FILL;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FILL;
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_hist  <= w_hist_next;
            r_fill  <= w_fill_next;
            r_match <= w_hit;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clear),
        .inc     (w_hit),
        .count   (match_count),
        .sat     (count_sat)
    );

    assign match = r_match;

endmodule

// File: tb/tb_seq_bit_pattern_det.sv
// Randomised and directed bench for seq_bit_pattern_det against a queue-based model.
module tb_seq_bit_pattern_det;

    localparam int unsigned PW      = 4;
    localparam logic [3:0]  PAT     = 4'b1011;
`ifdef SEQ_BIT_PATTERN_DET_NONOVERLAP_EN
    localparam bit          NonOvl  = 1'b1;
`else
    localparam bit          NonOvl  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       din = 1'b0;
    logic       din_val = 1'b0;
    logic       clear = 1'b0;
    logic       match, match3;
    logic [7:0] match_count;
    logic [2:0] match_count3;
    logic       count_sat, count_sat3;

    int n_vec = 0;
    int n_err = 0;
    bit run_cmp = 1'b0;

    always #5 clk = ~clk;

    seq_bit_pattern_det #(
        .PATTERN_W (PW),
        .PATTERN   (PAT),
        .CNT_W     (8)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .din         (din),
        .din_val     (din_val),
        .clear       (clear),
        .match       (match),
        .match_count (match_count),
        .count_sat   (count_sat)
    );

    seq_bit_pattern_det #(
        .PATTERN_W (PW),
        .PATTERN   (PAT),
        .CNT_W     (3)
    ) u_dut3 (
        .clk         (clk),
        .reset_n     (reset_n),
        .din         (din),
        .din_val     (din_val),
        .clear       (clear),
        .match       (match3),
        .match_count (match_count3),
        .count_sat   (count_sat3)
    );

    // Model: bits received since the last reset/clear (or match, non-overlapping).
    bit q[$];
    bit e_match = 1'b0;
    int e_cnt = 0;
    int e_cnt3 = 0;

    function automatic bit model_hit();
        logic [PW-1:0] win;
        if (q.size() != PW) return 1'b0;
        win = '0;
        foreach (q[i]) win = {win[PW-2:0], q[i]};
        return win == PAT;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            e_match <= 1'b0;
            e_cnt   <= 0;
            e_cnt3  <= 0;
        end else if (clear) begin
            q.delete();
            e_match <= 1'b0;
            e_cnt   <= 0;
            e_cnt3  <= 0;
        end else if (din_val) begin
            q.push_back(din);
            if (q.size() > PW) void'(q.pop_front());
            if (model_hit()) begin
                e_match <= 1'b1;
                e_cnt   <= (e_cnt == 255) ? e_cnt : e_cnt + 1;
                e_cnt3  <= (e_cnt3 == 7) ? e_cnt3 : e_cnt3 + 1;
                if (NonOvl) q.delete();
            end else begin
                e_match <= 1'b0;
            end
        end else begin
            e_match <= 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("match",        int'(match),        int'(e_match));
            chk("match_count",  int'(match_count),  e_cnt);
            chk("count_sat",    int'(count_sat),    int'(e_cnt == 255));
            chk("match3",       int'(match3),       int'(e_match));
            chk("match_count3", int'(match_count3), e_cnt3);
            chk("count_sat3",   int'(count_sat3),   int'(e_cnt3 == 7));
        end
    end

    task automatic drive(input bit b, input bit v, input bit c);
        @(negedge clk);
        din     = b;
        din_val = v;
        clear   = c;
    endtask

    task automatic send_pat();
        drive(1, 1, 0);
        drive(0, 1, 0);
        drive(1, 1, 0);
        drive(1, 1, 0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        run_cmp = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_match", int'(match), 0);
        chk("reset_count", int'(match_count), 0);
        reset_n = 1'b1;

        // 1: single pattern
        send_pat();
        after_edge();
        chk("t1_match", int'(match), 1);
        chk("t1_count", int'(match_count), 1);
        drive(0, 0, 0);
        after_edge();
        chk("t1_pulse_end", int'(match), 0);

        // 2: overlap stream 1011011
        drive(0, 0, 1);
        send_pat();
        drive(0, 1, 0);
        drive(1, 1, 0);
        drive(1, 1, 0);
        after_edge();
        chk("t2_count", int'(match_count), NonOvl ? 1 : 2);
        chk("t2_match7", int'(match), NonOvl ? 0 : 1);

        // 3: idle gaps with random din while idle
        drive(0, 0, 1);
        foreach (PAT[i]) begin
            repeat ($urandom_range(1, 3)) drive(1'($urandom), 0, 0);
            drive(PAT[i], 1, 0);
        end
        after_edge();
        chk("t3_match", int'(match), 1);
        chk("t3_count", int'(match_count), 1);

        // 4: saturation of the 3-bit counter
        drive(0, 0, 1);
        repeat (9) send_pat();
        after_edge();
        chk("t4_match9", int'(match3), 1);
        chk("t4_count3", int'(match_count3), 7);
        chk("t4_sat3", int'(count_sat3), 1);
        chk("t4_count8", int'(match_count), 9);

        // 5: clear discards a coincident valid bit
        drive(0, 0, 1);
        drive(1, 1, 0);
        drive(0, 1, 0);
        drive(1, 1, 0);
        drive(1, 1, 1);
        after_edge();
        chk("t5_clr_match", int'(match), 0);
        chk("t5_clr_count", int'(match_count), 0);
        send_pat();
        after_edge();
        chk("t5_match", int'(match), 1);
        chk("t5_count", int'(match_count), 1);

        // 6: async reset mid-cycle
        send_pat();
        send_pat();
        after_edge();
        chk("t6_count3", int'(match_count), 3);
        drive(1, 1, 0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_match", int'(match), 0);
        chk("t6_rst_count", int'(match_count), 0);
        chk("t6_rst_sat3", int'(count_sat3), 0);
        drive(0, 0, 0);
        reset_n = 1'b1;
        drive(1, 1, 0);
        drive(1, 1, 0);
        drive(1, 1, 0);
        after_edge();
        chk("t6_no_early", int'(match), 0);

        // Random soak
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 39) == 0));
        end
        drive(0, 0, 0);
        repeat (2) @(negedge clk);
        run_cmp = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
